// File: rtl/f2f_ctrl_pkg.sv
// Shared constants and result-entry type for the fixed2float converter arbiter.
package f2f_ctrl_pkg;

  localparam int unsigned FIXED_W   = 43;
  localparam int unsigned FLOAT_W   = 16;
  localparam int unsigned CONV_LAT  = 2;
  localparam int unsigned TAG_MAX_W = 8;

  function automatic int unsigned tag_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [TAG_MAX_W-1:0] tag;
    logic [FLOAT_W-1:0]   flt;
  } res_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request after the previous winner, wrapping.
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [PtrW-1:0]   gnt_idx_o
);

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            found;
  int unsigned     idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned off = 1; off <= NumReq; off++) begin
      idx = 32'(ptr_q) + off;
      if (idx >= NumReq) idx = idx - NumReq;
      if (en_i && !found && req_i[PtrW'(idx)]) begin
        found                 = 1'b1;
        gnt_o[PtrW'(idx)]     = 1'b1;
        gnt_idx_o             = PtrW'(idx);
      end
    end
  end

  assign ptr_d = found ? gnt_idx_o : ptr_q;

  // Pointer starts at the last lane so lane 0 wins first after reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) ptr_q <= PtrW'(NumReq - 1);
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fixed2float_arbiter.sv
// Shares one fixed-latency fixed2float converter between NUM_REQ lanes; results return in
// acceptance order through a credit-protected, tagged output FIFO.
module fixed2float_arbiter
  import f2f_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*FIXED_W-1:0]  req_data,
  output logic [FIXED_W-1:0]          conv_fixed,
  input  logic [FLOAT_W-1:0]          conv_float,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [FLOAT_W-1:0]          res_data,
  output logic [tag_w(NUM_REQ)-1:0]   res_tag,
  output logic                        busy
);

  localparam int unsigned TagW   = tag_w(NUM_REQ);
  // Stage 0 shadows the operand register; stages 1..CONV_LAT shadow the converter.
  localparam int unsigned Stages = CONV_LAT + 1;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);

  if (NUM_REQ < 2) begin : g_chk_req
    $error("fixed2float_arbiter: NUM_REQ must be >= 2");
  end
  if (FIFO_DEPTH < CONV_LAT + 2) begin : g_chk_depth
    $error("fixed2float_arbiter: FIFO_DEPTH must be >= CONV_LAT+2");
  end
  if (TagW > TAG_MAX_W) begin : g_chk_tag
    $error("fixed2float_arbiter: NUM_REQ too large for result tag field");
  end

  logic [FIXED_W-1:0] lane_data [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane_data[g] = req_data[g*FIXED_W +: FIXED_W];
  end

  logic [FIXED_W-1:0] fixed_q;
  logic [Stages-1:0]  vld_q;
  logic [TagW-1:0]    tag_q [Stages];
  res_entry_t         mem_q [FIFO_DEPTH];
  res_entry_t         head;
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [TagW-1:0]    gnt_idx;
  logic               can_issue, accept, push, pop;
  int unsigned        inflight;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < Stages; i++) inflight = inflight + 32'(vld_q[i]);
    can_issue = (32'(cnt_q) + inflight) < FIFO_DEPTH;
  end

  rr_arbiter #(
    .NumReq (NUM_REQ)
  ) u_arb (
    .clk_i     (clk),
    .reset_i   (reset),
    .en_i      (can_issue & ~reset),
    .req_i     (req_valid),
    .gnt_o     (req_ready),
    .gnt_idx_o (gnt_idx)
  );

  assign accept = |req_ready;
  assign push   = vld_q[Stages-1];
  assign pop    = res_valid & res_ready;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fixed_q  <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < Stages; i++)     tag_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      fixed_q  <= accept ? lane_data[gnt_idx] : '0;
      vld_q    <= {vld_q[Stages-2:0], accept};
      tag_q[0] <= gnt_idx;
      for (int i = 1; i < Stages; i++) tag_q[i] <= tag_q[i-1];
      if (push) begin
        mem_q[wr_ptr_q].tag <= TAG_MAX_W'(tag_q[Stages-1]);
        mem_q[wr_ptr_q].flt <= conv_float;
        wr_ptr_q <= (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      cnt_q <= cnt_d;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign conv_fixed = fixed_q;
  assign res_valid  = (cnt_q != '0);
  assign res_data   = head.flt;
  assign res_tag    = head.tag[TagW-1:0];
  assign busy       = (inflight != 0) || (cnt_q != '0);

endmodule

// File: tb/tb_fixed2float_arbiter.sv
// Directed and randomised bench for fixed2float_arbiter with a 2-cycle converter model.
module tb_fixed2float_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned FW = 43;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid, req_ready;
  logic [N*FW-1:0]   req_data;
  logic [FW-1:0]     conv_fixed;
  logic [15:0]       conv_float, cv1_q, cv2_q;
  logic              res_valid, res_ready;
  logic [15:0]       res_data;
  logic [1:0]        res_tag;
  logic              busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  tag;
    logic [15:0] flt;
  } ent_t;

  ent_t acc_q[$];
  ent_t pop_q[$];

  always #5 clk = ~clk;

  fixed2float_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .conv_fixed (conv_fixed),
    .conv_float (conv_float),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_tag    (res_tag),
    .busy       (busy)
  );

  // Toy converter mapping; only needs to be deterministic and data-dependent.
  function automatic logic [15:0] conv_f(input logic [42:0] x);
    return x[15:0] ^ x[31:16] ^ {5'b0, x[42:32]};
  endfunction

  always @(posedge clk) begin
    cv1_q <= conv_f(conv_fixed);
    cv2_q <= cv1_q;
  end
  assign conv_float = cv2_q;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i])
          acc_q.push_back(ent_t'{tag: 2'(i), flt: conv_f(req_data[i*FW +: FW])});
      if (res_valid && res_ready) pop_q.push_back(ent_t'{tag: res_tag, flt: res_data});
    end
  end

  always @(posedge clk) begin
    if (reset === 1'b0 && dut.push && !(res_valid && res_ready) && int'(dut.cnt_q) == 4) begin
      errors++;
      $display("FAIL fifo_push_full at %0t: push while FIFO holds 4 entries", $time);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [42:0] v);
    req_data[i*FW +: FW] = v;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    res_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    acc_q.delete();
    pop_q.delete();
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Returns -1 when popped results equal accepted requests, -2 on size mismatch, else index.
  function automatic int first_diff();
    if (acc_q.size() != pop_q.size()) return -2;
    foreach (acc_q[k]) if (acc_q[k] !== pop_q[k]) return k;
    return -1;
  endfunction

  // Run cycles with the given lanes requesting; accepted lanes get fresh data.
  task automatic run_lanes(input logic [N-1:0] lanes, input int max_cyc, input int stop_at,
                           inout int unsigned seed);
    logic [N-1:0] g;
    req_valid = lanes;
    for (int c = 0; c < max_cyc && acc_q.size() < stop_at; c++) begin
      @(negedge clk);
      g = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (g[i]) begin
          seed = seed + 32'h9e37;
          set_lane(i, 43'({seed, 11'(i)}));
        end
    end
    req_valid = '0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = '1;
    res_ready = 1'b0;
    for (int i = 0; i < N; i++) set_lane(i, 43'h123 + 43'(i));
    step();
    step();
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    checks++;
    if (conv_fixed !== 43'h0) begin errors++; $display("FAIL reset_conv_fixed got %h exp 0", conv_fixed); end
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
    checks++;
    if (res_data !== 16'h0) begin errors++; $display("FAIL reset_res_data got %h exp 0", res_data); end
    checks++;
    if (res_tag !== 2'd0) begin errors++; $display("FAIL reset_res_tag got %0d exp 0", res_tag); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    req_valid = '0;
    reset     = 1'b0;
    acc_q.delete();
    pop_q.delete();
  endtask

  task automatic test_single();
    res_ready = 1'b1;
    set_lane(2, 43'h400);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got %b exp 0100", req_ready); end
    step();  // E0
    req_valid = '0;
    checks++;
    if (conv_fixed !== 43'h400) begin errors++; $display("FAIL single_conv_fixed got %h exp 400", conv_fixed); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_e0 got %b exp 1", busy); end
    step();  // E1
    checks++;
    if (conv_fixed !== 43'h0) begin errors++; $display("FAIL single_conv_idle got %h exp 0", conv_fixed); end
    step();  // E2
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", res_valid); end
    step();  // E3
    checks++;
    if (res_valid !== 1'b1) begin errors++; $display("FAIL single_res_valid got %b exp 1", res_valid); end
    checks++;
    if (res_tag !== 2'd2) begin errors++; $display("FAIL single_res_tag got %0d exp 2", res_tag); end
    checks++;
    if (res_data !== 16'h0400) begin errors++; $display("FAIL single_res_data got %h exp 0400", res_data); end
    step();  // E4: popped
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL single_res_after_pop got %b exp 0", res_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_all_lanes();
    int unsigned seed = 32'h100;
    int bad = 0;
    int d;
    bit ok;
    do_reset();
    for (int i = 0; i < N; i++) set_lane(i, 43'h1000 * 43'(i + 1));
    run_lanes(4'b1111, 60, 12, seed);
    checks++;
    if (acc_q.size() != 12) begin errors++; $display("FAIL all_accepts got %0d exp 12", acc_q.size()); end
    foreach (acc_q[k]) if (acc_q[k].tag !== 2'(k % 4)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL all_grant_order got %0d bad grants exp 0", bad); end
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL all_drain got busy exp idle"); end
    d = first_diff();
    checks++;
    if (d != -1) begin errors++; $display("FAIL all_results got diff %0d (pops %0d accepts %0d) exp -1", d, pop_q.size(), acc_q.size()); end
  endtask

  task automatic test_rr_pair();
    int unsigned seed = 32'h200;
    int bad = 0;
    int d;
    bit ok;
    do_reset();
    set_lane(1, 43'h11);
    req_valid = 4'b0010;
    step();  // lane 1 accepted, pointer now 1
    req_valid = '0;
    drain(ok);
    acc_q.delete();
    pop_q.delete();
    set_lane(1, 43'h21);
    set_lane(3, 43'h23);
    run_lanes(4'b1010, 60, 8, seed);
    checks++;
    if (acc_q.size() != 8) begin errors++; $display("FAIL rr_accepts got %0d exp 8", acc_q.size()); end
    foreach (acc_q[k]) if (acc_q[k].tag !== ((k % 2 == 0) ? 2'd3 : 2'd1)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rr_order got %0d bad grants exp 0", bad); end
    drain(ok);
    d = first_diff();
    checks++;
    if (!ok || d != -1) begin errors++; $display("FAIL rr_results got diff %0d drained %0d exp -1 1", d, ok); end
  endtask

  task automatic test_backpressure();
    int unsigned seed = 32'h300;
    int d;
    bit ok;
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < N; i++) set_lane(i, 43'h7000 + 43'(i));
    run_lanes(4'b1111, 12, 100, seed);
    req_valid = '1;
    #1;
    checks++;
    if (acc_q.size() != 4) begin errors++; $display("FAIL bp_accepts got %0d exp 4", acc_q.size()); end
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_req_ready got %b exp 0000", req_ready); end
    checks++;
    if (res_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL bp_full_state got valid %b busy %b exp 1 1", res_valid, busy);
    end
    res_ready = 1'b1;
    run_lanes(4'b1111, 16, 100, seed);
    drain(ok);
    checks++;
    if (acc_q.size() <= 4) begin errors++; $display("FAIL bp_resume got %0d accepts exp >4", acc_q.size()); end
    d = first_diff();
    checks++;
    if (!ok || d != -1) begin errors++; $display("FAIL bp_results got diff %0d drained %0d exp -1 1", d, ok); end
  endtask

  task automatic test_reset_mid();
    int highs = 0;
    do_reset();
    for (int i = 0; i < N; i++) set_lane(i, 43'h5000 + 43'(i));
    req_valid = '1;
    step();
    step();  // two accepts: lanes 0 and 1
    reset     = 1'b1;
    req_valid = '0;
    step();
    reset = 1'b0;
    acc_q.delete();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
    for (int c = 0; c < 6; c++) begin
      if (res_valid !== 1'b0) highs++;
      step();
    end
    checks++;
    if (highs != 0 || pop_q.size() != 0) begin
      errors++; $display("FAIL rmid_no_result got %0d valid cycles %0d pops exp 0 0", highs, pop_q.size());
    end
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmid_first_grant got %b exp 0010", req_ready); end
    step();
    req_valid = '0;
    for (int c = 0; c < 6; c++) step();
  endtask

  task automatic test_random();
    logic [N-1:0] g;
    int d;
    bit ok;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      g = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (g[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 60);
          set_lane(i, 43'({$urandom(), $urandom()}));
        end
      res_ready = ($urandom_range(0, 99) < 70);
    end
    req_valid = '0;
    res_ready = 1'b1;
    drain(ok);
    checks++;
    if (acc_q.size() < 1000) begin errors++; $display("FAIL rand_activity got %0d accepts exp >=1000", acc_q.size()); end
    d = first_diff();
    checks++;
    if (!ok || d != -1) begin
      errors++; $display("FAIL rand_scoreboard got diff %0d (pops %0d accepts %0d) drained %0d exp -1", d, pop_q.size(), acc_q.size(), ok);
    end
  endtask

  initial begin
    req_data  = '0;
    req_valid = '0;
    res_ready = 1'b0;
    reset     = 1'b1;
    test_reset();
    test_single();
    test_all_lanes();
    test_rr_pair();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
